// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard-controller <-> pipeline bundle.
//   Hazard sources: ID source ids/uses, EX destination/load/mispredict, M mem op.
//   Memory handshake: m_mem_op, dmem_ready in; dmem_req out.
//   Controls: pc/if_id/id_ex/ex_m/m_wb 2-bit codes (00 normal, 01 stall, 10 bubble), pc_redirect.
//   master = hazard controller, slave = pipeline side.
interface pipe_hazard_ctrl_if;
    logic [4:0] id_rs1_id;
    logic [4:0] id_rs2_id;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] ex_rd_id;
    logic       ex_is_load;
    logic       ex_mispredict;
    logic       m_mem_op;
    logic       dmem_ready;
    logic       dmem_req;
    logic [1:0] pc_ctr;
    logic [1:0] if_id_ctr;
    logic [1:0] id_ex_ctr;
    logic [1:0] ex_m_ctr;
    logic [1:0] m_wb_ctr;
    logic       pc_redirect;

    modport master (
        input  id_rs1_id, id_rs2_id, id_uses_rs1, id_uses_rs2, ex_rd_id, ex_is_load,
               ex_mispredict, m_mem_op, dmem_ready,
        output dmem_req, pc_ctr, if_id_ctr, id_ex_ctr, ex_m_ctr, m_wb_ctr, pc_redirect
    );

    modport slave (
        output id_rs1_id, id_rs2_id, id_uses_rs1, id_uses_rs2, ex_rd_id, ex_is_load,
               ex_mispredict, m_mem_op, dmem_ready,
        input  dmem_req, pc_ctr, if_id_ctr, id_ex_ctr, ex_m_ctr, m_wb_ctr, pc_redirect
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: resolves memory wait, mispredict and load-use hazards into pipeline control codes.
//   clk, n_rst (async, active-low)
//   hif       : hazard inputs, dmem handshake, ctr codes and pc_redirect (master modport)
//   mem_err   : sticky memory-timeout error
//   stall_cnt : saturating count of memory-freeze and load-use stall cycles
//   flush_cnt : saturating count of mispredict flush cycles
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               n_rst,
    pipe_hazard_ctrl_if.master hif,
    output logic               mem_err,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);
    localparam int WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [1:0] NORM = 2'b00, STALL = 2'b01, BUB = 2'b10;

    typedef enum logic [1:0] {M_IDLE, M_WAIT, M_ERR} state_t;

    state_t           state_q, state_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             err, mem_stall, load_use, freeze, flush, lu_stall, timeout;

    always_comb begin
        err       = state_q == M_ERR;
        hif.dmem_req = hif.m_mem_op & !err;
        mem_stall = hif.dmem_req & !hif.dmem_ready;
        load_use  = hif.ex_is_load & (hif.ex_rd_id != 5'd0) &
                    ((hif.id_uses_rs1 & (hif.id_rs1_id == hif.ex_rd_id)) |
                     (hif.id_uses_rs2 & (hif.id_rs2_id == hif.ex_rd_id)));
        // A hazard masked by a freeze stays visible in the frozen EX/ID and is acted on once the freeze lifts.
        freeze    = err | mem_stall;
        flush     = !freeze & hif.ex_mispredict;
        lu_stall  = !freeze & !hif.ex_mispredict & load_use;
        hif.pc_ctr      = (freeze | lu_stall) ? STALL : NORM;
        hif.if_id_ctr   = (freeze | lu_stall) ? STALL : flush ? BUB : NORM;
        hif.id_ex_ctr   = freeze ? STALL : (flush | lu_stall) ? BUB : NORM;
        hif.ex_m_ctr    = freeze ? STALL : NORM;
        hif.m_wb_ctr    = freeze ? BUB : NORM;
        hif.pc_redirect = flush;
        // Fires on the cycle that would make MEM_TIMEOUT consecutive wait cycles.
        timeout   = (MEM_TIMEOUT != 0) && mem_stall && ((32'(wait_cnt_q) + 32'd1) == 32'(MEM_TIMEOUT));
        wait_cnt_d  = mem_stall ? wait_cnt_q + WW'(1) : '0;
        state_d     = (err | timeout) ? M_ERR : mem_stall ? M_WAIT : M_IDLE;
        mem_err_d   = state_d == M_ERR;
        stall_cnt_d = ((mem_stall | lu_stall) && !err && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (flush && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= M_IDLE;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard controller that drives the 2-bit `ctr` code of every pipeline register and the PC register. Code encoding: 00 = normal, 01 = stall (hold), 10 = bubble (clear).
- Resolves three hazards: data-memory wait states, branch mispredicts from EX, and load-use hazards in ID.
- Owns the data-memory request/ready handshake, a wait-state timeout, and saturating stall and flush counters.
- Sits in the core top level, between the stage datapaths and the IF/ID, ID/EX, EX/M and M/WB registers.

## Interface
Parameters:
- MEM_TIMEOUT, default 16: maximum consecutive memory wait cycles before error; 0 disables the timeout.
- CNT_W, default 32: width of the performance counters.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- id_rs1_id, id_rs2_id  in  5 each  source register ids of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction actually reads rs1 / rs2
- ex_rd_id  in  5  destination id of the instruction in EX
- ex_is_load  in  1  the EX instruction is a load
- ex_mispredict  in  1  the EX branch/jump resolved against its prediction
- m_mem_op  in  1  the M-stage instruction is a load or store
- dmem_ready  in  1  data memory completes the access this cycle
- dmem_req  out  1  data-memory request
- pc_ctr, if_id_ctr, id_ex_ctr, ex_m_ctr, m_wb_ctr  out  2 each  pipeline control codes
- pc_redirect  out  1  PC selects the corrected EX target this cycle
- mem_err  out  1  sticky memory-timeout error
- stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters

## Operation
- State machine states:
  - M_IDLE (reset state).
  - M_WAIT: memory access outstanding.
  - M_ERR: timeout; terminal until reset.
- Signal definitions:
  - `dmem_req = m_mem_op & (state != M_ERR)`.
  - `mem_stall = dmem_req & !dmem_ready`.
  - `load_use = ex_is_load & (ex_rd_id != 0) & ((id_uses_rs1 & id_rs1_id == ex_rd_id) | (id_uses_rs2 & id_rs2_id == ex_rd_id))`.
- Output priority, highest first, all combinational in the same cycle:
  1. state == M_ERR: pc, if_id, id_ex and ex_m = 01; m_wb = 10; pc_redirect = 0.
  2. mem_stall: pc, if_id, id_ex and ex_m = 01; m_wb = 10.
  3. ex_mispredict: pc = 00 with pc_redirect = 1; if_id = 10; id_ex = 10; ex_m and m_wb = 00.
  4. load_use: pc and if_id = 01; id_ex = 10; ex_m and m_wb = 00.
  5. Otherwise: all 00, pc_redirect = 0.
- pc_redirect is 1 only in case 3.
- A mispredict or load-use hazard coinciding with mem_stall is not lost. The EX and ID contents are frozen, so the hazard is re-evaluated and acted on in the first cycle mem_stall drops.
- Transitions:
  - M_IDLE → M_WAIT when mem_stall.
  - M_WAIT → M_IDLE when dmem_ready.
  - Any state → M_ERR when the wait-count limit is hit.
- wait_cnt behaviour:
  - Increments on every mem_stall cycle, including the first cycle in M_IDLE.
  - Clears on any cycle without mem_stall.
  - If MEM_TIMEOUT ≠ 0 and wait_cnt + 1 == MEM_TIMEOUT during a mem_stall cycle, the next state is M_ERR.
- m_mem_op dropping while in M_WAIT (for example on a squash) ends mem_stall; the state returns to M_IDLE.
- Counters:
  - stall_cnt +1 on each case-2 or case-4 cycle.
  - flush_cnt +1 on each case-3 cycle.
  - Both saturate at all-ones and never wrap. Neither counts in M_ERR.
- mem_err = (state == M_ERR), registered.

## Timing
- Only the state, wait_cnt, mem_err and the two counters are registered, all updated on posedge clk.
- All ctr outputs, dmem_req and pc_redirect are combinational, valid in the same cycle as their inputs, and sampled by the pipeline registers at the next edge.
- A zero-wait access (dmem_ready high with dmem_req) costs 0 stall cycles. An access with N wait cycles costs exactly N stall cycles.
- Values while n_rst is low: state M_IDLE, wait_cnt = 0, stall_cnt = 0, flush_cnt = 0, mem_err = 0. The outputs follow the priority table from M_IDLE; with all inputs low, every ctr = 00, dmem_req = 0 and pc_redirect = 0.
- Reset asserted mid-wait or in M_ERR returns the block to M_IDLE immediately (asynchronously), with counters and error cleared.

## Test plan
- Reset with all inputs 0: all ctr = 00, dmem_req = 0, pc_redirect = 0, mem_err = 0, both counters = 0.
- Load-use, with ex_is_load = 1, ex_rd_id = 5, id_rs1_id = 5, id_uses_rs1 = 1:
  - Response: pc = 01, if_id = 01, id_ex = 10, ex_m = 00, m_wb = 00; stall_cnt = 1 after the edge.
  - Repeat with ex_rd_id = 0, or with id_uses_rs1 = 0: all ctr = 00.
- m_mem_op = 1 with dmem_ready low for 3 cycles, then high:
  - Cycles 1–3: pc, if_id, id_ex and ex_m = 01; m_wb = 10.
  - Cycle 4: all 00.
  - Afterwards stall_cnt = 3 and state is M_IDLE.
- ex_mispredict = 1 together with load_use: flush wins, giving pc_redirect = 1, if_id = 10, id_ex = 10; flush_cnt = 1 and stall_cnt unchanged.
  - Repeat with mem_stall also active for 2 cycles: memory freeze for 2 cycles, then the flush pattern on cycle 3.
- MEM_TIMEOUT = 4, m_mem_op = 1, dmem_ready held 0:
  - Cycles 1–4: freeze pattern.
  - From cycle 5: mem_err = 1 and the M_ERR pattern, holding even after dmem_ready rises, until n_rst pulses low.
- CNT_W = 4 with 20 consecutive load-use cycles: stall_cnt stops at 15 and does not wrap.
